mem_access_ctrl: RTL



---
 rtl/mem_access_ctrl_pkg.sv | 31 +++
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/mem_access_ctrl_load_extend.sv | 12 +
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and the address legality check for the memory-stage controller.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE    = 2'd0,
        KIND_LOAD    = 2'd1,
        KIND_STORE   = 2'd2,
        KIND_ILLEGAL = 2'd3
    } kind_t;

    // True when the access must not reach memory: past the last byte, or a
    // word that is misaligned or would run off the end (no wrap-around).
    function automatic logic addr_fault(input logic [63:0] addr,
                                        input logic        is_byte,
                                        input int          addr_w);
        logic [63:0] last_byte;
        last_byte = (64'd1 << addr_w) - 64'd1;
        if (addr > last_byte)
            return 1'b1;
        if (!is_byte && ((addr[1:0] != 2'b00) || (addr > last_byte - 64'd3)))
            return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus data-memory bus. master = execute stage and
// memory side, slave = the controller.
interface mem_access_ctrl_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_is_load;
    logic             req_is_store;
    logic             req_is_byte;
    logic             req_signed;
    logic [N-1:0]     req_addr;
    logic [N-1:0]     req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic [N-1:0]     resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_fault;
    logic             store_done;
    logic [N-1:0]     mem_addr;
    logic [N-1:0]     mem_wdata;
    logic             mem_read_enable;
    logic             mem_write_enable;
    logic             mem_is_byte;
    logic [N-1:0]     mem_rdata;

    modport master (
        output req_valid, req_is_load, req_is_store, req_is_byte, req_signed,
               req_addr, req_wdata, req_tag, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_fault,
               store_done, mem_addr, mem_wdata, mem_read_enable,
               mem_write_enable, mem_is_byte
    );

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_is_byte, req_signed,
               req_addr, req_wdata, req_tag, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_tag, resp_fault,
               store_done, mem_addr, mem_wdata, mem_read_enable,
               mem_write_enable, mem_is_byte
    );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Load-data formatter: words pass through, bytes are masked and zero/sign extended.
module load_extend #(
    parameter int N = 32
) (
    input  logic [N-1:0] rdata,
    input  logic         is_byte,
    input  logic         sign_ext,
    output logic [N-1:0] data
);
    // Upper bits of a byte read are undefined on the memory side, so only [7:0] is used.
    assign data = is_byte ? {{(N-8){sign_ext & rdata[7]}}, rdata[7:0]} : rdata;
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: accepts one request per handshake, fires
// single-cycle read/write pulses, formats load data, and faults bad addresses.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 12,
    parameter int TAG_W  = 4
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    state_t           state, state_next;
    kind_t            req_kind, kind_q;
    logic             hs, accept, fault_in;
    logic             signed_q;
    logic [N-1:0]     ext_data;

    logic             rd_en, wr_en, resp_valid_q, resp_fault_q, store_done_q, is_byte_q;
    logic [N-1:0]     addr_q, wdata_q, resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;

    // Decode request kind and legality at the handshake.
    always_comb begin
        req_kind = KIND_NONE;
        case ({bus.req_is_load, bus.req_is_store})
            2'b10:   req_kind = KIND_LOAD;
            2'b01:   req_kind = KIND_STORE;
            2'b11:   req_kind = KIND_ILLEGAL;
            default: req_kind = KIND_NONE;
        endcase
    end

    assign hs       = bus.req_valid & (state == IDLE);
    assign accept   = hs & (req_kind != KIND_NONE);
    assign fault_in = (req_kind == KIND_ILLEGAL) |
                      addr_fault(64'(bus.req_addr), bus.req_is_byte, ADDR_W);

    load_extend #(.N(N)) u_ext (
        .rdata    (bus.mem_rdata),
        .is_byte  (is_byte_q),
        .sign_ext (signed_q),
        .data     (ext_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: faults skip ISSUE; stores return straight to IDLE after ISSUE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fault_in ? RESP : ISSUE;
            ISSUE:   state_next = (kind_q == KIND_LOAD) ? RESP : IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: pulses default low each cycle, so enables are clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en        <= 1'b0;
            wr_en        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            store_done_q <= 1'b0;
            is_byte_q    <= 1'b0;
            signed_q     <= 1'b0;
            kind_q       <= KIND_NONE;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            rd_en        <= 1'b0;
            wr_en        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            store_done_q <= 1'b0;
            if (accept) begin
                kind_q     <= req_kind;
                resp_tag_q <= bus.req_tag;
                if (fault_in) begin
                    // Report immediately; memory-side registers keep the last issued access.
                    resp_data_q  <= '0;
                    resp_fault_q <= 1'b1;
                    if (req_kind == KIND_STORE) store_done_q <= 1'b1;
                    else                        resp_valid_q <= 1'b1;
                end else begin
                    addr_q    <= bus.req_addr;
                    is_byte_q <= bus.req_is_byte;
                    signed_q  <= bus.req_signed;
                    wdata_q   <= bus.req_is_byte ? {{(N-8){1'b0}}, bus.req_wdata[7:0]}
                                                 : bus.req_wdata;
                    rd_en     <= (req_kind == KIND_LOAD);
                    wr_en     <= (req_kind == KIND_STORE);
                end
            end
            if (state == ISSUE) begin
                if (kind_q == KIND_LOAD) begin
                    resp_data_q  <= ext_data;
                    resp_valid_q <= 1'b1;
                end else begin
                    store_done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready        = (state == IDLE);
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_data        = resp_data_q;
    assign bus.resp_tag         = resp_tag_q;
    assign bus.resp_fault       = resp_fault_q;
    assign bus.store_done       = store_done_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.mem_read_enable  = rd_en;
    assign bus.mem_write_enable = wr_en;
    assign bus.mem_is_byte      = is_byte_q;
endmodule
